dac_serial_tx: RTL and testbench

Serial transmitter for the 12-bit DAC. It sits directly downstream of the offset-add/saturation stage and consumes that stage's `anchosalida`-bit unsigned sample. On a start strobe it latches one sample, prepends the control bits, and shifts the frame out MSB-first over a SYNC/SCLK/DIN three-wire link. The DAC samples DIN on the falling edge of SCLK.

---
 rtl/dac_serial_tx.sv | 157 +++++++++++++++
 tb/tb_dac_serial_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - SYNC/SCLK/DIN serial frame transmitter for the 12-bit DAC
//
// Latches one anchosalida-bit unsigned sample on a start strobe, prepends the
// 4 control bits and shifts the N = anchosalida+4 bit frame out MSB-first.
// The DAC samples sdata on sclk falling edges; sdata only changes on rising ones.
//
// Optional feature macro: DAC_OVERRUN_FLAG_EN
//   defined   : desborde is a sticky flag set by a start strobe seen while busy
//   undefined : desborde is tied to 0 (port kept so both builds match)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   dato      in   sample from the offset/saturation stage
//   inicio    in   one-cycle start strobe
//   sclk      out  serial clock, idles high
//   sync_n    out  frame select, active low
//   sdata     out  serial data, MSB first
//   ocupado   out  frame in progress
//   listo     out  one-cycle end-of-frame pulse
//   desborde  out  sticky overrun flag

module dac_serial_tx #(
    parameter int         anchosalida = 12,
    parameter int         DIVISOR     = 4,
    parameter logic [3:0] CTRL        = 4'b0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [anchosalida-1:0] dato,
    input  logic                   inicio,
    output logic                   sclk,
    output logic                   sync_n,
    output logic                   sdata,
    output logic                   ocupado,
    output logic                   listo,
    output logic                   desborde
);

    localparam int N  = anchosalida + 4;
    localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int BW = $clog2(N + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        ENVIO  = 2'd1,
        FIN    = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_shift;
    logic [DW-1:0]  r_div;
    logic [BW-1:0]  r_bit;
    logic           r_sclk;
    logic           w_tc;
    logic           w_rise;
    logic           w_last;

    // Divider terminal count; a toggle from low is a rising sclk edge.
    assign w_tc   = (r_state == ENVIO) && (r_div == DIV_LAST);
    assign w_rise = w_tc && !r_sclk;
    assign w_last = w_rise && (r_bit == BIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= REPOSO;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            REPOSO:  if (inicio) w_next = ENVIO;
            ENVIO:   if (w_last) w_next = FIN;
            FIN:     w_next = REPOSO;
            default: w_next = REPOSO;
        endcase
    end

    // Output logic
    always_comb begin
        sync_n  = 1'b1;
        ocupado = 1'b0;
        listo   = 1'b0;
        sdata   = 1'b0;
        case (r_state)
            ENVIO: begin
                sync_n  = 1'b0;
                ocupado = 1'b1;
                sdata   = r_shift[N-1];
            end
            FIN:     listo = 1'b1;
            default: ;
        endcase
    end

    assign sclk = r_sclk;

    // Datapath: shift register, sclk divider and bit counter.
    // The last rising toggle leaves sclk high, so the link idles with sclk=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b1;
        end else begin
            case (r_state)
                REPOSO: begin
                    if (inicio) begin
                        r_shift <= {CTRL, dato};
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= 1'b1;
                    end
                end
                ENVIO: begin
                    if (w_tc) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        if (w_rise) begin
                            r_shift <= {r_shift[N-2:0], 1'b0};
                            r_bit   <= r_bit + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DAC_OVERRUN_FLAG_EN
    logic r_desborde;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_desborde <= 1'b0;
        end else if (inicio && (r_state != REPOSO)) begin
            r_desborde <= 1'b1;
        end
    end

    assign desborde = r_desborde;
`else
    assign desborde = 1'b0;
`endif

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - directed table-driven bench for dac_serial_tx

module tb_dac_serial_tx;

    logic        clk;
    logic        reset;
    logic [11:0] dato;
    logic        inicio;
    logic        sclk, sync_n, sdata, ocupado, listo, desborde;

    logic        d1_reset;
    logic [11:0] d1_dato;
    logic        d1_inicio;
    logic        d1_sclk, d1_sync_n, d1_sdata, d1_ocupado, d1_listo, d1_desborde;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DAC_OVERRUN_FLAG_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    dac_serial_tx u_dut (
        .clk      (clk),
        .reset    (reset),
        .dato     (dato),
        .inicio   (inicio),
        .sclk     (sclk),
        .sync_n   (sync_n),
        .sdata    (sdata),
        .ocupado  (ocupado),
        .listo    (listo),
        .desborde (desborde)
    );

    dac_serial_tx #(.DIVISOR(1)) u_dut_d1 (
        .clk      (clk),
        .reset    (d1_reset),
        .dato     (d1_dato),
        .inicio   (d1_inicio),
        .sclk     (d1_sclk),
        .sync_n   (d1_sync_n),
        .sdata    (d1_sdata),
        .ocupado  (d1_ocupado),
        .listo    (d1_listo),
        .desborde (d1_desborde)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [11:0] d;
        logic [15:0] frame;
    } vec_t;

    // Runs one frame on the default-DIVISOR DUT. c counts cycles after the
    // acceptance edge k; sampling is at the negedge inside each cycle.
    task automatic run_frame(input logic [11:0] d, input int busy_at,
                             output logic [15:0] cap, output int nfall,
                             output int nbusy, output int nsync,
                             output int t_listo, output int t_fall,
                             output int sclk_bad);
        logic ps, py;
        cap = '0; nfall = 0; nbusy = 0; nsync = 0;
        t_listo = 0; t_fall = 0; sclk_bad = 0;
        ps = 1'b1; py = 1'b1;
        @(negedge clk);
        dato   = d;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        for (int c = 1; c <= 400 && t_listo == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (ps && !sclk) begin
                cap = {cap[14:0], sdata};
                nfall++;
                if (t_fall == 0) t_fall = c;
            end
            if (ocupado) nbusy++;
            if (!sync_n) nsync++;
            if ((sync_n != py) && !sclk) sclk_bad++;
            if (listo) t_listo = c;
            ps = sclk;
            py = sync_n;
            inicio = (c == busy_at);
            dato   = (c == busy_at) ? 12'h123 : 12'($urandom);
        end
    endtask

    vec_t        tbl[4];
    logic [15:0] cap;
    int          nfall, nbusy, nsync, t_listo, t_fall, sclk_bad;

    initial begin
        tbl[0] = '{d: 12'hA5C, frame: 16'h0A5C};
        tbl[1] = '{d: 12'hFFF, frame: 16'h0FFF};
        tbl[2] = '{d: 12'h000, frame: 16'h0000};
        tbl[3] = '{d: 12'h801, frame: 16'h0801};

        reset = 1'b1; inicio = 1'b0; dato = '0;
        d1_reset = 1'b1; d1_inicio = 1'b0; d1_dato = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", int'(sclk), 1);
        check("rst_sync_n", int'(sync_n), 1);
        check("rst_sdata", int'(sdata), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_listo", int'(listo), 0);
        check("rst_desborde", int'(desborde), 0);
        reset = 1'b0;
        d1_reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].d, 0, cap, nfall, nbusy, nsync, t_listo, t_fall, sclk_bad);
            check($sformatf("frame_bits[%0d]", i), int'(cap), int'(tbl[i].frame));
            check($sformatf("nfall[%0d]", i), nfall, 16);
            check($sformatf("busy_cycles[%0d]", i), nbusy, 128);
            check($sformatf("sync_low[%0d]", i), nsync, 128);
            check($sformatf("listo_at[%0d]", i), t_listo, 129);
            check($sformatf("first_fall[%0d]", i), t_fall, 5);
            check($sformatf("sclk_at_sync_edge[%0d]", i), sclk_bad, 0);
        end
        @(negedge clk);
        check("listo_single_pulse", int'(listo), 0);
        check("idle_after_fin", int'(ocupado), 0);
        check("no_overrun_yet", int'(desborde), 0);

        // Start strobe in the middle of a frame.
        run_frame(12'hA5C, 50, cap, nfall, nbusy, nsync, t_listo, t_fall, sclk_bad);
        check("busy_start_frame", int'(cap), 16'h0A5C);
        check("busy_start_busy", nbusy, 128);
        check("busy_start_listo", t_listo, 129);
        check("desborde", int'(desborde), int'(EXP_OVR));
        @(negedge clk);
        check("busy_start_not_taken", int'(ocupado), 0);

        // Reset mid-frame at cycle k+40.
        @(negedge clk);
        dato = 12'hFFF; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (39) @(negedge clk);
        check("pre_reset_busy", int'(ocupado), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_sync_n", int'(sync_n), 1);
        check("midrst_sclk", int'(sclk), 1);
        check("midrst_ocupado", int'(ocupado), 0);
        check("midrst_listo", int'(listo), 0);
        check("midrst_desborde", int'(desborde), 0);
        reset = 1'b0;
        run_frame(12'h5A3, 0, cap, nfall, nbusy, nsync, t_listo, t_fall, sclk_bad);
        check("after_rst_frame", int'(cap), 16'h05A3);
        check("after_rst_busy", nbusy, 128);
        check("after_rst_listo", t_listo, 129);

        // Reset and start in the same cycle: reset wins.
        @(negedge clk);
        reset = 1'b1; inicio = 1'b1;
        @(negedge clk);
        reset = 1'b0; inicio = 1'b0;
        @(negedge clk);
        check("rst_beats_inicio", int'(ocupado), 0);

        // Back-to-back: inicio held high, dato changes every cycle.
        begin
            logic        po, ps;
            logic [15:0] exp_f, bcap;
            int          frames, t_prev, bn;
            po = 1'b0; ps = 1'b1; frames = 0; t_prev = 0; bcap = '0; bn = 0; exp_f = '0;
            dato = 12'h3E7; inicio = 1'b1;
            for (int c = 1; c <= 600 && frames < 3; c++) begin
                @(negedge clk);
                if (ocupado && !po) begin
                    if (t_prev != 0) check($sformatf("b2b_spacing[%0d]", frames), c - t_prev, 130);
                    t_prev = c;
                    exp_f  = {4'h0, dato};
                    bcap   = '0;
                    bn     = 0;
                end
                if (ps && !sclk) begin
                    bcap = {bcap[14:0], sdata};
                    bn++;
                end
                if (listo) begin
                    check($sformatf("b2b_frame[%0d]", frames), int'(bcap), int'(exp_f));
                    check($sformatf("b2b_nfall[%0d]", frames), bn, 16);
                    frames++;
                end
                po = ocupado;
                ps = sclk;
                dato = 12'(c * 291 + 7);
            end
            inicio = 1'b0;
            check("b2b_frames_done", frames, 3);
        end

        // DIVISOR=1 instance.
        begin
            logic        ps;
            logic [15:0] dcap;
            int          dn, dbusy, dlisto, dfall, dtog;
            ps = 1'b1; dcap = '0; dn = 0; dbusy = 0; dlisto = 0; dfall = 0; dtog = 0;
            @(negedge clk);
            d1_dato = 12'h3C6; d1_inicio = 1'b1;
            @(negedge clk);
            d1_inicio = 1'b0;
            for (int c = 1; c <= 100 && dlisto == 0; c++) begin
                if (c > 1) @(negedge clk);
                if (ps && !d1_sclk) begin
                    dcap = {dcap[14:0], d1_sdata};
                    dn++;
                    if (dfall == 0) dfall = c;
                end
                if (d1_ocupado) begin
                    dbusy++;
                    if (c > 1 && d1_sclk != ps) dtog++;
                end
                if (d1_listo) dlisto = c;
                ps = d1_sclk;
                d1_dato = 12'($urandom);
            end
            check("d1_frame", int'(dcap), 16'h03C6);
            check("d1_nfall", dn, 16);
            check("d1_busy", dbusy, 32);
            check("d1_listo_at", dlisto, 33);
            check("d1_first_fall", dfall, 2);
            check("d1_toggles", dtog, 31);
            check("d1_sclk_idle", int'(d1_sclk), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
